// File: rtl/cpa_pkg.sv
// Shared types and sizing helpers for the compressor-tree CPA/accumulator back-end.
package cpa_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } cpa_state_e;

    // Width of sum + 2*carry for W-bit redundant inputs; 3*(2^W-1) always fits.
    function automatic int value_width(input int w);
        return w + 2;
    endfunction

    function automatic int cnt_width(input int beats);
        int c;
        c = $clog2(beats);
        return (c < 1) ? 1 : c;
    endfunction

endpackage

// File: rtl/cpa_merge.sv
// Resolves a redundant (sum, carry) pair into a binary value: sum + 2*carry.
module cpa_merge
    import cpa_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [W-1:0]                  sum_vec,
    input  logic [W-1:0]                  carry_vec,
    output logic [value_width(W)-1:0]     value
);

    always_comb begin
        value = {2'b00, sum_vec} + {1'b0, carry_vec, 1'b0};
    end

endmodule

// File: rtl/cpa_accumulator.sv
// Final CPA-plus-MAC stage: merges each redundant beat and accumulates BEATS beats
// into one saturating result presented on a valid/ready output.
module cpa_accumulator
    import cpa_pkg::*;
#(
    parameter int W     = 16,
    parameter int ACC_W = 32,  // must be >= W+2
    parameter int BEATS = 4    // must be >= 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     sum_vec,
    input  logic [W-1:0]     carry_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             out_ovf
);

    localparam int VW = value_width(W);
    localparam int CW = cnt_width(BEATS);
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

    // Handshake: a beat moves when in_valid && in_ready, and clear vetoes it;
    // the result retires when out_valid && out_ready. in_ready is combinational
    // from out_ready so a result can retire and a new beat enter in one cycle.

    cpa_state_e state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d;
    logic [ACC_W-1:0] acc_out_q, acc_out_d;
    logic             out_ovf_q, out_ovf_d;

    logic [VW-1:0]    value;
    logic [ACC_W:0]   value_ext;
    logic [ACC_W:0]   sum_t;
    logic [ACC_W-1:0] acc_next;
    logic             ovf_next;
    logic             beat_acc;

    cpa_merge #(
        .W(W)
    ) u_merge (
        .sum_vec  (sum_vec),
        .carry_vec(carry_vec),
        .value    (value)
    );

    assign in_ready  = (state_q != DONE) || out_ready;
    assign beat_acc  = in_valid && in_ready && !clear;
    assign out_valid = out_valid_q;
    assign acc_out   = acc_out_q;
    assign out_ovf   = out_ovf_q;

    // Once acc is all ones any non-zero value carries out, so saturation is sticky.
    always_comb begin
        value_ext = {{(ACC_W + 1 - VW){1'b0}}, value};
        sum_t     = {1'b0, acc_q} + value_ext;
        if (sum_t[ACC_W]) begin
            acc_next = '1;
            ovf_next = 1'b1;
        end else begin
            acc_next = sum_t[ACC_W-1:0];
            ovf_next = ovf_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        acc_out_d   = acc_out_q;
        out_ovf_d   = out_ovf_q;

        if (clear) begin
            state_d     = IDLE;
            cnt_d       = '0;
            acc_d       = '0;
            ovf_d       = 1'b0;
            out_valid_d = 1'b0;
        end else begin
            if (state_q == DONE && out_ready) begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
            // acc/ovf/cnt are already zero in DONE, so a beat there starts a fresh frame.
            if (beat_acc) begin
                if (cnt_q == LAST) begin
                    acc_out_d   = acc_next;
                    out_ovf_d   = ovf_next;
                    out_valid_d = 1'b1;
                    acc_d       = '0;
                    ovf_d       = 1'b0;
                    cnt_d       = '0;
                    state_d     = DONE;
                end else begin
                    acc_d   = acc_next;
                    ovf_d   = ovf_next;
                    cnt_d   = cnt_q + CW'(1);
                    state_d = ACC;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            acc_out_q   <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            acc_out_q   <= acc_out_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

endmodule

// File: tb/tb_cpa_accumulator.sv
// Directed bench for cpa_accumulator: three configurations share one stimulus stream.
module tb_cpa_accumulator;
    import cpa_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic [7:0] sum_vec = '0;
    logic [7:0] carry_vec = '0;

    logic        a_in_ready, a_out_valid, a_out_ovf;
    logic [11:0] a_acc_out;
    logic        s_in_ready, s_out_valid, s_out_ovf;
    logic [10:0] s_acc_out;
    logic        b_in_ready, b_out_valid, b_out_ovf;
    logic [11:0] b_acc_out;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cpa_accumulator #(.W(8), .ACC_W(12), .BEATS(4)) u_a (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(a_in_ready),
        .sum_vec(sum_vec), .carry_vec(carry_vec), .out_valid(a_out_valid), .out_ready(out_ready),
        .acc_out(a_acc_out), .out_ovf(a_out_ovf)
    );

    cpa_accumulator #(.W(8), .ACC_W(11), .BEATS(4)) u_s (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(s_in_ready),
        .sum_vec(sum_vec), .carry_vec(carry_vec), .out_valid(s_out_valid), .out_ready(out_ready),
        .acc_out(s_acc_out), .out_ovf(s_out_ovf)
    );

    cpa_accumulator #(.W(8), .ACC_W(12), .BEATS(1)) u_b (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(b_in_ready),
        .sum_vec(sum_vec), .carry_vec(carry_vec), .out_valid(b_out_valid), .out_ready(out_ready),
        .acc_out(b_acc_out), .out_ovf(b_out_ovf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic beat(input logic [7:0] s, input logic [7:0] c);
        sum_vec   = s;
        carry_vec = c;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
    endtask

    initial begin
        // reset state
        do_reset();
        check("rst_valid", a_out_valid, 0);
        check("rst_acc", a_acc_out, 0);
        check("rst_ovf", a_out_ovf, 0);
        check("rst_state", 32'(u_a.state_q), 32'(IDLE));
        check("rst_cnt", 32'(u_a.cnt_q), 0);
        check("rst_in_ready", a_in_ready, 1);

        // basic frame, BEATS=1 instance echoes each value
        out_ready = 1'b1;
        beat(8'd1, 8'd0);
        check("b1_acc1", b_acc_out, 12'd1);
        check("b1_valid1", b_out_valid, 1);
        beat(8'd2, 8'd1);
        check("b1_acc2", b_acc_out, 12'd4);
        beat(8'd3, 8'd2);
        check("b1_acc3", b_acc_out, 12'd7);
        check("basic_not_yet", a_out_valid, 0);
        beat(8'd4, 8'd3);
        check("b1_acc4", b_acc_out, 12'd10);
        check("basic_valid", a_out_valid, 1);
        check("basic_acc", a_acc_out, 12'h016);
        check("basic_ovf", a_out_ovf, 0);
        tick();
        check("basic_one_cycle", a_out_valid, 0);
        check("basic_idle", 32'(u_a.state_q), 32'(IDLE));

        // max merge / saturation at ACC_W=11
        do_reset();
        for (int i = 0; i < 4; i++) beat(8'hFF, 8'hFF);
        check("max_acc", a_acc_out, 12'hBF4);
        check("max_ovf", a_out_ovf, 0);
        check("sat_acc", s_acc_out, 11'h7FF);
        check("sat_ovf", s_out_ovf, 1);
        check("sat_valid", s_out_valid, 1);
        for (int i = 0; i < 4; i++) beat(8'd1, 8'd0);
        check("after_sat_acc", s_acc_out, 11'h004);
        check("after_sat_ovf", s_out_ovf, 0);
        check("after_max_acc", a_acc_out, 12'h004);
        // exactly all ones without overflow: 765+765+255+262 = 2047
        beat(8'hFF, 8'hFF);
        beat(8'hFF, 8'hFF);
        beat(8'hFF, 8'h00);
        beat(8'h00, 8'h83);
        check("exact_acc", s_acc_out, 11'h7FF);
        check("exact_ovf", s_out_ovf, 0);
        tick();

        // backpressure then simultaneous pop and push
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) beat(8'd1, 8'd0);
        check("bp_valid", a_out_valid, 1);
        check("bp_acc", a_acc_out, 12'h004);
        sum_vec   = 8'd7;
        carry_vec = 8'd0;
        in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_in_ready", a_in_ready, 0);
            tick();
            check("bp_hold_acc", a_acc_out, 12'h004);
            check("bp_hold_valid", a_out_valid, 1);
        end
        out_ready = 1'b1;
        #1;
        check("ovl_in_ready", a_in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("ovl_valid", a_out_valid, 0);
        check("ovl_state", 32'(u_a.state_q), 32'(ACC));
        check("ovl_cnt", 32'(u_a.cnt_q), 1);
        for (int i = 0; i < 3; i++) beat(8'd1, 8'd0);
        check("ovl_acc", a_acc_out, 12'h00A);
        check("ovl_done_valid", a_out_valid, 1);
        tick();

        // clear mid-frame, then clear in DONE
        do_reset();
        beat(8'd5, 8'd0);
        beat(8'd6, 8'd0);
        clear = 1'b1;
        beat(8'd9, 8'd0);
        clear = 1'b0;
        check("clr_state", 32'(u_a.state_q), 32'(IDLE));
        check("clr_cnt", 32'(u_a.cnt_q), 0);
        check("clr_acc", 32'(u_a.acc_q), 0);
        check("clr_valid", a_out_valid, 0);
        for (int i = 0; i < 4; i++) beat(8'd1, 8'd1);
        check("clr_frame_acc", a_acc_out, 12'h00C);
        check("clr_frame_valid", a_out_valid, 1);
        out_ready = 1'b0;
        clear     = 1'b1;
        tick();
        clear     = 1'b0;
        check("clr_done_valid", a_out_valid, 0);
        check("clr_done_keep", a_acc_out, 12'h00C);
        check("clr_done_in_ready", a_in_ready, 1);
        out_ready = 1'b1;

        // reset mid-frame after 3 beats
        for (int i = 0; i < 3; i++) beat(8'd2, 8'd0);
        do_reset();
        check("mid_rst_acc", a_acc_out, 0);
        check("mid_rst_valid", a_out_valid, 0);
        check("mid_rst_cnt", 32'(u_a.cnt_q), 0);
        check("mid_rst_b_acc", b_acc_out, 0);
        for (int i = 0; i < 4; i++) beat(8'd2, 8'd0);
        check("mid_rst_frame", a_acc_out, 12'h008);
        check("mid_rst_b_val", b_acc_out, 12'h002);
        check("mid_rst_b_valid", b_out_valid, 1);
        tick();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/cpa_accumulator.md
Name: cpa_accumulator

Overview:
- Downstream consumer of the 4:2 compressor column array.
- Each input beat carries a redundant (sum, carry) vector pair. The block resolves the pair with a carry-propagate add (sum + 2*carry) and accumulates BEATS consecutive beats into one saturating result.
- The result is presented on a valid/ready output. This block is the final CPA-plus-MAC stage behind the compressor tree.

Parameters:
- W, 16, width of each of sum_vec and carry_vec
- ACC_W, 32, accumulator / result width; must satisfy ACC_W >= W+2
- BEATS, 4, accepted beats per accumulation frame; must be >= 1

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- clear  input  1  synchronous frame abort; drops any partial frame and any pending result
- in_valid  input  1  sum_vec/carry_vec valid
- in_ready  output  1  block can accept a beat this cycle
- sum_vec  input  W  compressor sum bits, weight 2^i
- carry_vec  input  W  compressor carry bits, weight 2^(i+1)
- out_valid  output  1  acc_out/out_ovf hold a completed frame
- out_ready  input  1  downstream accepts the result
- acc_out  output  ACC_W  frame sum, saturated
- out_ovf  output  1  frame saturated at least once

Behaviour:
- Clocking and reset: one clock domain. Reset is synchronous and active-low on rst_n, sampled at the clk rising edge.
- Reset values: state=IDLE, beat_cnt=0, acc=0, ovf=0, out_valid=0, acc_out=0, out_ovf=0.
- Merge (combinational):
  - value = zext(sum_vec) + (zext(carry_vec) << 1), width VW = W+2 (max 3*(2^W-1); cannot overflow VW).
  - value is zero-extended to ACC_W+1 for the add.
- Beat acceptance: a beat is accepted when in_valid && in_ready && !clear.
- On an accepted beat:
  - t = acc + value, computed at ACC_W+1 bits.
  - If t[ACC_W] is set, acc_next = all ones and ovf_next = 1; otherwise acc_next = t[ACC_W-1:0].
- in_ready = (state != DONE) || out_ready. This is a combinational path from out_ready.
- States:
  - IDLE: no beats held; acc=0, cnt=0.
  - ACC: 1..BEATS-1 beats held.
  - DONE: result presented.
- IDLE/ACC transitions on an accepted beat:
  - If cnt == BEATS-1: acc_out <= acc_next, out_ovf <= ovf_next, out_valid <= 1, acc <= 0, ovf <= 0, cnt <= 0, go to DONE.
  - Otherwise: acc <= acc_next, ovf <= ovf_next, cnt <= cnt+1, go to ACC.
- BEATS == 1: every accepted beat goes straight to DONE.
- Latency: the result is visible the cycle after the last beat is accepted.
- DONE with out_ready=1 and no accepted beat: out_valid <= 0, go to IDLE.
- DONE with out_ready=1 and an accepted beat (simultaneous pop and push):
  - The result retires and the beat becomes beat 1 of the new frame.
  - Next state is ACC, or DONE again if BEATS == 1.
  - No bubble is inserted.
- DONE with out_ready=0: hold acc_out, out_ovf and out_valid stable; in_ready=0.
- clear (priority over every beat and every handshake):
  - Next cycle: state=IDLE, acc=0, ovf=0, cnt=0, out_valid=0.
  - acc_out and out_ovf keep their old values but are invalid.
- Reset mid-frame or mid-DONE: all state returns to reset values; the partial frame is discarded.
- Saturation is sticky within a frame: later beats cannot leave saturation. acc stays all ones because t always overflows once acc is all ones and value > 0; a value of 0 keeps acc all ones.
- out_ovf is 0 when the final sum is exactly 2^ACC_W-1 without any overflow.

Decomposition:
- Shared package cpa_pkg holds:
  - the state enum {IDLE, ACC, DONE};
  - the function value_width(W) = W+2;
  - the function cnt_width(BEATS) = max(1, $clog2(BEATS)).
- Sub-module cpa_merge (combinational, parameter W): sum_vec, carry_vec -> value[W+1:0]. It is reusable by other tree back-ends.
- The FSM, counter, saturating adder and output register stay in cpa_accumulator.

Test Plan (W=8, ACC_W=12, BEATS=4 unless stated):
- Basic frame: beats (s,c) = (1,0),(2,1),(3,2),(4,3), back-to-back, out_ready=1 -> values 1,4,7,10; one cycle after beat 4, out_valid=1, acc_out=0x016, out_ovf=0, for exactly 1 cycle.
- Max merge: 4 beats of (0xFF,0xFF) -> each value 765; acc_out=0xBF4, out_ovf=0.
- Saturation (ACC_W=11): 4 beats of (0xFF,0xFF) -> overflow on beat 3; acc_out=0x7FF, out_ovf=1; the next frame of 4x(1,0) gives 0x004, out_ovf=0.
- Backpressure and overlap:
  - Complete a frame with out_ready=0 for 5 cycles -> in_ready=0, acc_out stable.
  - Then raise out_ready with in_valid=1 in the same cycle -> the result retires and the beat counts as beat 1 of the next frame (cnt=1, state ACC).
- Clear: 2 beats (5,0),(6,0), then clear with in_valid=1 -> the beat is ignored and state is IDLE; the next 4x(1,1) gives 0x00C. Repeat with clear asserted in DONE -> out_valid drops the next cycle.
- Reset: drop rst_n for 1 cycle mid-frame after 3 beats -> all outputs reset; the next 4x(2,0) gives 0x008. Repeat with BEATS=1: every accepted beat yields out_valid the next cycle with acc_out=value.
